seg7_scan6: RTL and testbench

//  Downstream display stage for the 12-hour clock timer. Takes its packed-BCD hour/min/sec

---
 rtl/seg7_scan6_pkg.sv | 53 +++++
 rtl/seg7_scan6_if.sv | 27 ++
 rtl/seg7_scan6_bcd_to_seg7.sv | 30 +++
 rtl/seg7_scan6.sv | 147 ++++++++++++++
 tb/tb_seg7_scan6.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/seg7_scan6_pkg.sv
// Shared types and constants for the 6-digit 7-segment scanner.
// Latency: n/a (constants and one pure function).
// Backpressure: n/a.
//
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package seg7_scan6_pkg;

   typedef logic [6:0] seg_t;
   typedef logic [2:0] dig_idx_t;

   // Snapshot of the timer's packed-BCD time fields.
   typedef struct packed {
      logic [7:0] hour;
      logic [7:0] min;
      logic [7:0] sec;
   } time_t;

   localparam seg_t SEG_0    = 7'h3F;
   localparam seg_t SEG_1    = 7'h06;
   localparam seg_t SEG_2    = 7'h5B;
   localparam seg_t SEG_3    = 7'h4F;
   localparam seg_t SEG_4    = 7'h66;
   localparam seg_t SEG_5    = 7'h6D;
   localparam seg_t SEG_6    = 7'h7D;
   localparam seg_t SEG_7    = 7'h07;
   localparam seg_t SEG_8    = 7'h7F;
   localparam seg_t SEG_9    = 7'h6F;
   localparam seg_t SEG_DASH = 7'h40;
   localparam seg_t SEG_OFF  = 7'h00;

   localparam dig_idx_t DIG_SEC_ONES  = 3'd0;
   localparam dig_idx_t DIG_SEC_TENS  = 3'd1;
   localparam dig_idx_t DIG_MIN_ONES  = 3'd2;
   localparam dig_idx_t DIG_MIN_TENS  = 3'd3;
   localparam dig_idx_t DIG_HOUR_ONES = 3'd4;
   localparam dig_idx_t DIG_HOUR_TENS = 3'd5;

   // Decimal points after hour-ones and min-ones give hh.mm.ss.
   localparam logic [5:0] DP_MASK = 6'b010100;

   // Pick the BCD nibble shown on a given digit position.
   function automatic logic [3:0] digit_nibble(input time_t t, input dig_idx_t i);
      case (i)
         DIG_SEC_ONES:  return t.sec[3:0];
         DIG_SEC_TENS:  return t.sec[7:4];
         DIG_MIN_ONES:  return t.min[3:0];
         DIG_MIN_TENS:  return t.min[7:4];
         DIG_HOUR_ONES: return t.hour[3:0];
         default:       return t.hour[7:4];
      endcase
   endfunction

endpackage

// File: rtl/seg7_scan6_if.sv
// Bundle between the clock timer and the display scanner.
// Latency: n/a (wires only).
// Backpressure: none; time fields are level signals, display outputs free-run.
//
// Signals: ihour/imin/isec packed BCD, iblank_lz leading-zero blank,
//          iblink field blink enables (only with SEG_BLINK_EN defined),
//          osel digit enables, oseg {g,f,e,d,c,b,a}, odp decimal point.
interface seg7_scan6_if;
   logic [7:0] ihour;
   logic [7:0] imin;
   logic [7:0] isec;
   logic       iblank_lz;
`ifdef SEG_BLINK_EN
   logic [2:0] iblink;
`endif
   logic [5:0] osel;
   logic [6:0] oseg;
   logic       odp;

`ifdef SEG_BLINK_EN
   modport master (output ihour, imin, isec, iblank_lz, iblink, input osel, oseg, odp);
   modport slave  (input ihour, imin, isec, iblank_lz, iblink, output osel, oseg, odp);
`else
   modport master (output ihour, imin, isec, iblank_lz, input osel, oseg, odp);
   modport slave  (input ihour, imin, isec, iblank_lz, output osel, oseg, odp);
`endif
endinterface

// File: rtl/seg7_scan6_bcd_to_seg7.sv
// BCD nibble to active-high 7-segment pattern; A-F render as a dash.
// Latency: combinational.
// Backpressure: none.
//
// Ports: bcd in 4, seg out 7 {g,f,e,d,c,b,a}.
module bcd_to_seg7
   import seg7_scan6_pkg::*;
(
   input  logic [3:0] bcd,
   output seg_t       seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan6.sv
// 6-digit multiplexed 7-segment scanner with per-frame snapshot and per-dwell blanking.
// Latency: inputs shown from the next frame start; all outputs registered (1 cycle).
// Backpressure: none; free-running scan, inputs sampled once per frame.
//
// Ports: iclk clock, irst async active-high reset, bus (seg7_scan6_if.slave):
//        ihour/imin/isec/iblank_lz[/iblink] in, osel[5:0]/oseg[6:0]/odp out.
// Optional feature: define SEG_BLINK_EN for iblink field flashing.
module seg7_scan6
   import seg7_scan6_pkg::*;
#(
   parameter int CLK_HZ         = 50_000_000,
   parameter int SCAN_HZ        = 6000,
   parameter int BLANK_CYC      = 64,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int SEL_ACTIVE_LOW = 1,
   parameter int BLINK_FRAMES   = 250
)(
   input  logic        iclk,
   input  logic        irst,
   seg7_scan6_if.slave bus
);

   localparam int DIV = CLK_HZ / SCAN_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] DIV_LAST  = PW'(DIV - 1);
   localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);

   localparam logic [5:0] SEL_OFF   = (SEL_ACTIVE_LOW != 0) ? 6'h3F : 6'h00;
   localparam logic [6:0] SEG_UNLIT = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic       DP_UNLIT  = (SEG_ACTIVE_LOW != 0);

   // Dwell must leave at least a couple of lit cycles after the blanking gap.
   if (DIV < BLANK_CYC + 2 || BLINK_FRAMES < 1) begin : g_cfg_err
      $error("seg7_scan6: CLK_HZ/SCAN_HZ must be >= BLANK_CYC+2 and BLINK_FRAMES >= 1");
   end

   logic [PW-1:0] presc_q, presc_nxt;
   dig_idx_t      idx_q, idx_nxt;
   time_t         shadow_q, shadow_nxt;
   logic [5:0]    osel_q;
   logic [6:0]    oseg_q;
   logic          odp_q;

   logic          tick;
   logic          wrap;
   logic [3:0]    nib;
   seg_t          dec_seg;
   logic          lz_off;
   logic          field_off;
   seg_t          seg_on;
   logic          dp_on;
   logic [5:0]    sel_on;

   assign tick = (presc_q == DIV_LAST);
   assign wrap = tick && (idx_q == DIG_HOUR_TENS);

   always_comb begin
      presc_nxt  = tick ? '0 : presc_q + PW'(1);
      idx_nxt    = idx_q;
      shadow_nxt = shadow_q;
      if (tick) begin
         idx_nxt = wrap ? DIG_SEC_ONES : idx_q + 3'd1;
      end
      // Snapshot only at the frame boundary so a frame never tears.
      if (wrap) begin
         shadow_nxt = '{hour: bus.ihour, min: bus.imin, sec: bus.isec};
      end
   end

`ifdef SEG_BLINK_EN
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

   logic [FW-1:0] frame_q, frame_nxt;
   logic          phase_q, phase_nxt;
   logic [2:0]    blink_q, blink_nxt;

   always_comb begin
      frame_nxt = frame_q;
      phase_nxt = phase_q;
      blink_nxt = blink_q;
      if (wrap) begin
         blink_nxt = bus.iblink;
         if (frame_q == FRAME_LAST) begin
            frame_nxt = '0;
            phase_nxt = ~phase_q;
         end else begin
            frame_nxt = frame_q + FW'(1);
         end
      end
   end

   // idx/2 selects the field: 0 sec, 1 min, 2 hour (iblink is {hour,min,sec}).
   assign field_off = phase_nxt && blink_nxt[idx_nxt[2:1]];

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         frame_q <= '0;
         phase_q <= 1'b0;
         blink_q <= 3'b000;
      end else begin
         frame_q <= frame_nxt;
         phase_q <= phase_nxt;
         blink_q <= blink_nxt;
      end
   end
`else
   assign field_off = 1'b0;
`endif

   // Outputs are built from next-state so segment data for a new digit
   // lands on the same edge its enable is dropped for the blanking gap.
   assign nib = digit_nibble(shadow_nxt, idx_nxt);

   bcd_to_seg7 u_dec (
      .bcd (nib),
      .seg (dec_seg)
   );

   assign lz_off = bus.iblank_lz && (idx_nxt == DIG_HOUR_TENS) && (shadow_nxt.hour[7:4] == 4'd0);
   assign seg_on = (lz_off || field_off) ? SEG_OFF : dec_seg;
   assign dp_on  = DP_MASK[idx_nxt] && !field_off;
   assign sel_on = (presc_nxt >= BLANK_END) ? (6'b000001 << idx_nxt) : 6'b000000;

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         presc_q  <= '0;
         idx_q    <= DIG_SEC_ONES;
         shadow_q <= '0;
         osel_q   <= SEL_OFF;
         oseg_q   <= SEG_UNLIT;
         odp_q    <= DP_UNLIT;
      end else begin
         presc_q  <= presc_nxt;
         idx_q    <= idx_nxt;
         shadow_q <= shadow_nxt;
         osel_q   <= (SEL_ACTIVE_LOW != 0) ? ~sel_on : sel_on;
         oseg_q   <= (SEG_ACTIVE_LOW != 0) ? ~seg_on : seg_on;
         odp_q    <= (SEG_ACTIVE_LOW != 0) ? ~dp_on  : dp_on;
      end
   end

   assign bus.osel = osel_q;
   assign bus.oseg = oseg_q;
   assign bus.odp  = odp_q;

endmodule

// File: tb/tb_seg7_scan6.sv
// Testbench for seg7_scan6 at DIV=10, BLANK_CYC=2, BLINK_FRAMES=2, active-low outputs.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg7_scan6;

   logic iclk;
   logic irst;

   seg7_scan6_if bus ();

   seg7_scan6 #(
      .CLK_HZ         (1000),
      .SCAN_HZ        (100),
      .BLANK_CYC      (2),
      .SEG_ACTIVE_LOW (1),
      .SEL_ACTIVE_LOW (1),
      .BLINK_FRAMES   (2)
   ) dut (
      .iclk (iclk),
      .irst (irst),
      .bus  (bus)
   );

   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   // Hand-computed active-high patterns, pat[i] is digit i.
   typedef struct packed {
      logic [7:0]      h;
      logic [7:0]      m;
      logic [7:0]      s;
      logic            lz;
      logic [5:0][6:0] pat;
   } vec_t;

   vec_t vecs [5];

   int checks   = 0;
   int failures = 0;

   logic [6:0] seg_cap [6];
   logic [5:0] dp_cap;
   int         low_cnt [6];
   int         sel_bad;

   localparam logic [5:0] DP_EXP = 6'b101011;  // low (lit) on idx 2 and 4

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [6:0] lo(input logic [6:0] p);
      return ~p;
   endfunction

   // Observes one whole frame; call at #1 after the edge before the frame-wrap edge.
   task automatic capture(input int chg_k, input logic [7:0] chg_sec);
      sel_bad = 0;
      for (int d = 0; d < 6; d++) low_cnt[d] = 0;
      for (int k = 0; k < 60; k++) begin
         int d;
         int p;
         logic [5:0] exp_sel;
         logic [5:0] one_cold;
         @(posedge iclk);
         #1;
         d = k / 10;
         p = k % 10;
         one_cold = ~(6'b000001 << d);
         exp_sel = (p < 2) ? 6'h3F : one_cold;
         if (bus.osel !== exp_sel) sel_bad++;
         if (bus.osel === one_cold) low_cnt[d]++;
         if (p == 5) begin
            seg_cap[d] = bus.oseg;
            dp_cap[d]  = bus.odp;
         end
         if (k == chg_k) bus.isec = chg_sec;
      end
   endtask

   // Releases reset away from an edge, checks the first two cycles, and
   // stops at #1 after edge 59 (last cycle of frame 0).
   task automatic release_align(input string tag);
      @(negedge iclk);
      irst = 1'b0;
      @(posedge iclk);
      #1;
      chk({tag, "_n1_sel"}, bus.osel, 6'h3F);
      chk({tag, "_n1_seg_zero"}, bus.oseg, 7'h40);
      chk({tag, "_n1_dp"}, bus.odp, 1'b1);
      @(posedge iclk);
      #1;
      chk({tag, "_n2_sel_idx0"}, bus.osel, 6'h3E);
      repeat (57) @(posedge iclk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{h: 8'h12, m: 8'h34, s: 8'h56, lz: 1'b0,
                  pat: {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D}};
      vecs[1] = '{h: 8'h05, m: 8'h59, s: 8'h0C, lz: 1'b1,
                  pat: {7'h00, 7'h6D, 7'h6D, 7'h6F, 7'h3F, 7'h40}};
      vecs[2] = '{h: 8'h05, m: 8'h59, s: 8'h0C, lz: 1'b0,
                  pat: {7'h3F, 7'h6D, 7'h6D, 7'h6F, 7'h3F, 7'h40}};
      vecs[3] = '{h: 8'h10, m: 8'h08, s: 8'h47, lz: 1'b1,
                  pat: {7'h06, 7'h3F, 7'h3F, 7'h7F, 7'h66, 7'h07}};
      vecs[4] = '{h: 8'hFA, m: 8'hB0, s: 8'h93, lz: 1'b1,
                  pat: {7'h40, 7'h40, 7'h40, 7'h3F, 7'h6F, 7'h4F}};

      irst          = 1'b1;
      bus.ihour     = vecs[0].h;
      bus.imin      = vecs[0].m;
      bus.isec      = vecs[0].s;
      bus.iblank_lz = vecs[0].lz;
`ifdef SEG_BLINK_EN
      bus.iblink    = 3'b000;
`endif
      repeat (3) @(posedge iclk);
      #1;
      chk("reset_sel", bus.osel, 6'h3F);
      chk("reset_seg", bus.oseg, 7'h7F);
      chk("reset_dp", bus.odp, 1'b1);

      release_align("start");

      // Table: inputs applied just before the wrap edge show for the whole next frame.
      for (int i = 0; i < 5; i++) begin
         bus.ihour     = vecs[i].h;
         bus.imin      = vecs[i].m;
         bus.isec      = vecs[i].s;
         bus.iblank_lz = vecs[i].lz;
         capture(-1, 8'h00);
         for (int d = 0; d < 6; d++)
            chk($sformatf("v%0d_seg%0d", i, d), seg_cap[d], lo(vecs[i].pat[d]));
         chk($sformatf("v%0d_dp", i), dp_cap, DP_EXP);
         chk($sformatf("v%0d_sel_walk", i), sel_bad, 0);
         if (i == 0)
            for (int d = 0; d < 6; d++)
               chk($sformatf("v0_sel_low_cycles%0d", d), low_cnt[d], 8);
      end

      // Mid-frame second change must wait for the next frame boundary.
      bus.ihour     = 8'h12;
      bus.imin      = 8'h34;
      bus.isec      = 8'h56;
      bus.iblank_lz = 1'b0;
      capture(-1, 8'h00);
      capture(2, 8'h57);
      chk("midframe_old_sec_ones", seg_cap[0], lo(7'h7D));
      chk("midframe_old_sec_tens", seg_cap[1], lo(7'h6D));
      capture(-1, 8'h00);
      chk("nextframe_new_sec_ones", seg_cap[0], lo(7'h07));
      chk("nextframe_hour_tens", seg_cap[5], lo(7'h06));

      // Reset mid-dwell (idx3, lit), asserted between clock edges.
      repeat (35) @(posedge iclk);
      #2;
      irst = 1'b1;
      #1;
      chk("midreset_sel_async", bus.osel, 6'h3F);
      chk("midreset_seg_async", bus.oseg, 7'h7F);
      chk("midreset_dp_async", bus.odp, 1'b1);
      repeat (2) @(posedge iclk);
      #1;
      chk("midreset_sel_held", bus.osel, 6'h3F);

      bus.isec = 8'h56;
`ifdef SEG_BLINK_EN
      bus.iblink = 3'b010;
`endif
      release_align("restart");

`ifdef SEG_BLINK_EN
      // Phase 0 for frames 0-1, 1 for 2-3, 0 for 4-5, 1 for 6.
      for (int f = 1; f <= 6; f++) begin
         logic unlit;
         unlit = (f == 2) || (f == 3) || (f == 6);
         capture(-1, 8'h00);
         chk($sformatf("blink_f%0d_min_ones", f), seg_cap[2], unlit ? 7'h7F : lo(7'h66));
         chk($sformatf("blink_f%0d_min_tens", f), seg_cap[3], unlit ? 7'h7F : lo(7'h4F));
         chk($sformatf("blink_f%0d_dp2", f), dp_cap[2], unlit ? 1'b1 : 1'b0);
         chk($sformatf("blink_f%0d_sec_ones", f), seg_cap[0], lo(7'h7D));
         chk($sformatf("blink_f%0d_dp4", f), dp_cap[4], 1'b0);
         chk($sformatf("blink_f%0d_sel_walk", f), sel_bad, 0);
      end
`else
      capture(-1, 8'h00);
      for (int d = 0; d < 6; d++)
         chk($sformatf("restart_seg%0d", d), seg_cap[d], lo(vecs[0].pat[d]));
      chk("restart_sel_walk", sel_bad, 0);
      chk("restart_dp", dp_cap, DP_EXP);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
